// File: rtl/quick_spi_pkg.sv
// rtl/quick_spi_pkg.sv - shared FSM encoding, mode bit positions and limits for the SPI arbiter
package quick_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LATCH     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    localparam int MODE_CPOL = 0;
    localparam int MODE_CPHA = 1;
    localparam int MAX_LEN   = 16;

    // Index width that never collapses to zero bits for single-entry sets.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick starting at ptr with wrap
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    // Scan offsets high to low so the lowest offset from ptr is assigned last and wins.
    always_comb begin
        int j;
        valid  = 1'b0;
        winner = '0;
        j      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (req[j]) begin
                valid  = 1'b1;
                winner = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/quick_spi_arbiter.sv
// rtl/quick_spi_arbiter.sv - round-robin arbiter sharing one SPI engine among NUM_REQ requesters
module quick_spi_arbiter
    import quick_spi_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int NUMBER_OF_SLAVES = 2,
    parameter int GAP_CYCLES       = 2,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic [NUM_REQ-1:0]                            req,
    input  logic [NUM_REQ*idx_width(NUMBER_OF_SLAVES)-1:0] req_slave,
    input  logic [NUM_REQ*2-1:0]                          req_mode,
    input  logic [NUM_REQ*5-1:0]                          req_len,
    input  logic [NUM_REQ*16-1:0]                         req_wdata,
    output logic [NUM_REQ-1:0]                            gnt,
    output logic [NUM_REQ-1:0]                            done,
    output logic [NUM_REQ-1:0]                            err,
    output logic [15:0]                                   rdata,
    output logic                                          eng_start,
    output logic [idx_width(NUMBER_OF_SLAVES)-1:0]        eng_slave,
    output logic                                          eng_cpol,
    output logic                                          eng_cpha,
    output logic [4:0]                                    eng_len,
    output logic [15:0]                                   eng_wdata,
    output logic                                          eng_abort,
    input  logic                                          eng_busy,
    input  logic                                          eng_done,
    input  logic [15:0]                                   eng_rdata
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int SW    = idx_width(NUMBER_OF_SLAVES);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW    = $clog2(GAP_CYCLES + 2);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   pick;
    logic               pick_valid;
    logic [TW-1:0]      tcnt;
    logic [GW-1:0]      gap_cnt;
    logic [NUM_REQ-1:0] pick_mask;
    logic [NUM_REQ-1:0] win_mask;
    logic [IDX_W-1:0]   next_ptr;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

    assign pick_mask = NUM_REQ'(1) << pick;
    assign win_mask  = NUM_REQ'(1) << winner;
    assign next_ptr  = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    // tcnt equals the number of cycles elapsed since the eng_start cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            winner    <= '0;
            tcnt      <= '0;
            gap_cnt   <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            rdata     <= '0;
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            eng_slave <= '0;
            eng_cpol  <= 1'b0;
            eng_cpha  <= 1'b0;
            eng_len   <= '0;
            eng_wdata <= '0;
        end else begin
            done      <= '0;
            err       <= '0;
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid && !eng_busy) begin
                        winner    <= pick;
                        gnt       <= pick_mask;
                        eng_slave <= req_slave[int'(pick)*SW +: SW];
                        eng_cpol  <= req_mode[int'(pick)*2 + MODE_CPOL];
                        eng_cpha  <= req_mode[int'(pick)*2 + MODE_CPHA];
                        eng_len   <= req_len[int'(pick)*5 +: 5];
                        eng_wdata <= req_wdata[int'(pick)*16 +: 16];
                        state     <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (eng_len == 5'd0 || eng_len > 5'(MAX_LEN)) begin
                        err     <= win_mask;
                        gnt     <= '0;
                        ptr     <= next_ptr;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        eng_start <= 1'b1;
                        tcnt      <= '0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    tcnt  <= tcnt + 1'b1;
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (eng_done) begin
                        rdata   <= eng_rdata;
                        done    <= win_mask;
                        gnt     <= '0;
                        ptr     <= next_ptr;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (tcnt + 1'b1 == TW'(TIMEOUT_CYCLES - 1)) begin
                        eng_abort <= 1'b1;
                        err       <= win_mask;
                        gnt       <= '0;
                        ptr       <= next_ptr;
                        gap_cnt   <= '0;
                        state     <= ST_GAP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt + 1'b1 >= GW'(GAP_CYCLES)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// tb/tb_quick_spi_arbiter.sv - directed self-checking bench for quick_spi_arbiter
module tb_quick_spi_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  req_slave;
    logic [7:0]  req_mode;
    logic [19:0] req_len;
    logic [63:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic [15:0] rdata;
    logic        eng_start;
    logic [0:0]  eng_slave;
    logic        eng_cpol;
    logic        eng_cpha;
    logic [4:0]  eng_len;
    logic [15:0] eng_wdata;
    logic        eng_abort;
    logic        eng_busy;
    logic        eng_done;
    logic [15:0] eng_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n;
    int prev_start;
    logic [3:0] seen;

    quick_spi_arbiter #(
        .NUM_REQ          (4),
        .NUMBER_OF_SLAVES (2),
        .GAP_CYCLES       (2),
        .TIMEOUT_CYCLES   (1024)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_slave (req_slave),
        .req_mode  (req_mode),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .eng_start (eng_start),
        .eng_slave (eng_slave),
        .eng_cpol  (eng_cpol),
        .eng_cpha  (eng_cpha),
        .eng_len   (eng_len),
        .eng_wdata (eng_wdata),
        .eng_abort (eng_abort),
        .eng_busy  (eng_busy),
        .eng_done  (eng_done),
        .eng_rdata (eng_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (gnt == 4'd0 && k < 40);
        check({tag, "_gnt_seen"}, 32'(gnt != 4'd0), 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = 4'd0;
        req_slave = 4'b0101;
        req_mode  = {2'b11, 2'b00, 2'b01, 2'b10};
        req_len   = {5'd8, 5'd8, 5'd8, 5'd8};
        req_wdata = {16'h4444, 16'h3333, 16'h2222, 16'hA5A5};
        eng_busy  = 1'b0;
        eng_done  = 1'b0;
        eng_rdata = 16'h0;
        repeat (3) tick();
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_start", eng_start, 0);
        check("rst_abort", eng_abort, 0);
        check("rst_len", eng_len, 0);
        check("rst_wdata", eng_wdata, 0);
        check("rst_mode", {eng_slave, eng_cpol, eng_cpha}, 0);
        reset_n = 1'b1;
        tick();

        // Single transaction from requester 0 with latency checks
        req = 4'b0001;
        tick();
        check("s1_gnt", gnt, 4'b0001);
        check("s1_start_early", eng_start, 0);
        check("s1_len", eng_len, 8);
        check("s1_slave", eng_slave, 1);
        check("s1_cpha", eng_cpha, 1);
        check("s1_cpol", eng_cpol, 0);
        check("s1_wdata", eng_wdata, 16'hA5A5);
        tick();
        check("s1_start", eng_start, 1);
        tick();
        check("s1_start_pulse", eng_start, 0);
        repeat (8) tick();
        check("s1_no_early_done", done, 0);
        eng_rdata = 16'h1234;
        eng_done  = 1'b1;
        tick();
        eng_done = 1'b0;
        check("s1_done", done, 4'b0001);
        check("s1_rdata", rdata, 16'h1234);
        check("s1_err", err, 0);
        check("s1_gnt_drop", gnt, 0);
        req = 4'd0;
        tick();
        check("s1_done_pulse", done, 0);
        repeat (4) tick();

        // Owner drops its request after the grant
        req = 4'b0010;
        tick();
        check("s2_gnt", gnt, 4'b0010);
        req = 4'd0;
        tick();
        check("s2_start", eng_start, 1);
        check("s2_gnt_held", gnt, 4'b0010);
        check("s2_wdata", eng_wdata, 16'h2222);
        repeat (3) tick();
        eng_rdata = 16'hBEEF;
        eng_done  = 1'b1;
        tick();
        eng_done = 1'b0;
        check("s2_done", done, 4'b0010);
        check("s2_rdata", rdata, 16'hBEEF);
        repeat (4) tick();

        // Zero length on requester 2
        req_len[14:10] = 5'd0;
        req = 4'b0100;
        tick();
        check("s3_gnt", gnt, 4'b0100);
        tick();
        check("s3_err", err, 4'b0100);
        check("s3_gnt_drop", gnt, 0);
        check("s3_start", eng_start, 0);
        check("s3_done", done, 0);
        req = 4'd0;
        req_len[14:10] = 5'd8;
        seen = 4'd0;
        repeat (5) begin
            tick();
            seen = seen | {3'd0, eng_start};
        end
        check("s3_no_start", seen, 0);

        // ptr must now be 3; requester 3 times out
        req = 4'b1001;
        tick();
        check("s4_ptr", gnt, 4'b1000);
        req = 4'd0;
        tick();
        check("s4_start", eng_start, 1);
        n = 0;
        seen = 4'd0;
        while (!eng_abort && n < 1100) begin
            tick();
            n++;
            seen = seen | done;
        end
        check("s4_abort_cycle", n, 1023);
        check("s4_err", err, 4'b1000);
        check("s4_no_done", seen, 0);
        check("s4_rdata", rdata, 16'hBEEF);
        tick();
        check("s4_abort_pulse", eng_abort, 0);
        check("s4_err_pulse", err, 0);
        repeat (4) tick();

        // Reset during WAIT_DONE
        req = 4'b0001;
        tick();
        check("s5_gnt", gnt, 4'b0001);
        tick();
        tick();
        reset_n = 1'b0;
        req = 4'd0;
        tick();
        check("s5_gnt", gnt, 0);
        check("s5_rdata", rdata, 0);
        check("s5_len", eng_len, 0);
        check("s5_wdata", eng_wdata, 0);
        check("s5_pulses", {done, err, eng_abort, eng_start}, 0);
        reset_n  = 1'b1;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        seen = done | err;
        repeat (3) begin
            tick();
            seen = seen | done | err;
        end
        check("s5_no_pulse", seen, 0);

        // All four requesting: strict rotation with idle gap between starts
        req = 4'b1111;
        prev_start = -100;
        for (int k = 0; k < 5; k++) begin
            wait_gnt("rr");
            check("rr_gnt", gnt, 32'd1 << (k % 4));
            tick();
            check("rr_start", eng_start, 1);
            if (k > 0) check("rr_gap", 32'((cyc - prev_start) >= 3), 32'd1);
            prev_start = cyc;
            repeat (2) tick();
            eng_rdata = 16'(k + 16'h50);
            eng_done  = 1'b1;
            tick();
            eng_done = 1'b0;
            check("rr_done", done, 32'd1 << (k % 4));
            check("rr_rdata", rdata, 32'(k + 16'h50));
        end
        req = 4'd0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quick_spi_arbiter.md
QUICK_SPI_ARBITER -- requirements
Module: quick_spi_arbiter

Interface
REQ-001 The block SHALL expose the following parameters, one per line: name, default, meaning.
- NUM_REQ, 4, number of requesters sharing one SPI engine.
- NUMBER_OF_SLAVES, 2, number of slave-select lines on the engine.
- GAP_CYCLES, 2, minimum idle clk cycles between engine transactions.
- TIMEOUT_CYCLES, 1024, maximum clk cycles from eng_start to eng_done.
REQ-002 The block SHALL expose the following ports, one per line: name, direction, width, meaning. Clock and reset are synchronous: reset reset_n, synchronous, active-low; clock clk.
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  level request per requester.
- req_slave  in  NUM_REQ*clog2(NUMBER_OF_SLAVES)  target slave index per requester.
- req_mode  in  NUM_REQ*2  {CPHA,CPOL} per requester.
- req_len  in  NUM_REQ*5  bit count per requester, 1..16.
- req_wdata  in  NUM_REQ*16  write data per requester.
- gnt  out  NUM_REQ  one-hot ownership, held while owned.
- done  out  NUM_REQ  one-cycle completion pulse.
- err  out  NUM_REQ  one-cycle error pulse.
- rdata  out  16  last captured read data.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_slave  out  clog2(NUMBER_OF_SLAVES)  registered slave index.
- eng_cpol, eng_cpha  out  1 each  registered mode bits.
- eng_len  out  5  registered bit count.
- eng_wdata  out  16  registered write data.
- eng_abort  out  1  one-cycle abort pulse.
- eng_busy  in  1  engine busy.
- eng_done  in  1  engine completion pulse.
- eng_rdata  in  16  engine read data.

Function
REQ-003 The FSM SHALL have states IDLE, LATCH, START, WAIT_DONE, GAP.
REQ-004 In IDLE with any req bit set and eng_busy=0, the block SHALL select the winner by round-robin, searching from index ptr upward with wrap, and SHALL go to LATCH.
REQ-005 In LATCH, the block SHALL register the winner's slave, mode, len and wdata onto the eng_* outputs and assert gnt[winner].
REQ-006 If the latched len is 0 or greater than 16, the block SHALL pulse err[winner], issue no eng_start, and go to GAP.
REQ-007 In START, the block SHALL pulse eng_start for exactly 1 cycle, clear the timeout counter, and go to WAIT_DONE.
REQ-008 Latency from req asserted in IDLE SHALL be: gnt at cycle +1, eng_start at cycle +2.
REQ-009 In WAIT_DONE on eng_done, the block SHALL load rdata from eng_rdata, pulse done[winner] in the same cycle as the rdata update, and go to GAP.
REQ-010 In WAIT_DONE, if the timeout counter reaches TIMEOUT_CYCLES-1 without eng_done, the block SHALL pulse eng_abort and err[winner], leave rdata unchanged, and go to GAP.
REQ-011 If eng_done and the timeout occur in the same cycle, eng_done SHALL win (done pulse, no err).
REQ-012 On GAP entry, the block SHALL deassert gnt and set ptr = (winner+1) mod NUM_REQ.
REQ-013 GAP SHALL last GAP_CYCLES cycles, then return to IDLE; with GAP_CYCLES=0 it SHALL return to IDLE on the next cycle.
REQ-014 Deassertion of req by the owner during LATCH, START or WAIT_DONE SHALL be ignored; the transaction completes normally.
REQ-015 gnt SHALL be one-hot or zero at all times; done and err SHALL never pulse together.
REQ-016 eng_* data outputs SHALL remain stable from LATCH until the next LATCH.
REQ-017 eng_done seen outside WAIT_DONE SHALL be ignored.

Reset
REQ-018 On reset, the block SHALL drive gnt=0, done=0, err=0, rdata=0, eng_start=0, eng_abort=0, eng_slave=0, eng_cpol=0, eng_cpha=0, eng_len=0, eng_wdata=0, ptr=0, state=IDLE, and clear all counters.
REQ-019 Reset asserted mid-transaction SHALL abandon it without a done, err or eng_abort pulse.

Structure
REQ-020 Shared package quick_spi_pkg SHALL hold the FSM state encoding, the mode bit positions (CPOL=0, CPHA=1), and the maximum length constant 16.
REQ-021 Round-robin selection SHALL live in one sub-module, rr_picker, which is combinational with inputs req and ptr and outputs winner index and valid.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- req=4'b0001, len=8, eng_done at +10 -> gnt[0] at +1, eng_start at +2, done[0] pulse, rdata=eng_rdata.
- req=4'b1111 held, GAP_CYCLES=2 -> grant order 0,1,2,3,0; at least 2 idle cycles between eng_start pulses.
- req[2] with len=0 -> err[2] pulse, no eng_start, ptr=3.
- No eng_done, TIMEOUT_CYCLES=1024 -> eng_abort and err[winner] at cycle 1023 after eng_start; rdata unchanged.
- reset_n low during WAIT_DONE -> all outputs at reset values next cycle; no done/err pulse.
- req[1] dropped after gnt -> transaction completes, done[1] still pulses.
